// File: rtl/vot_chk_pkg.sv
// Shared definitions for the majority-voter response checker.
package vot_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of distinct input vectors for an n-input voter.
  function automatic int unsigned num_vec(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/vot_resp_check_if.sv
// Stimulus/response and result bundle between a check driver and vot_resp_check.
interface vot_resp_check_if #(
  parameter int unsigned NO_IN = 3
);
  logic             start;
  logic [NO_IN-1:0] stimul;
  logic             stimul_vld;
  logic             vot;
  logic [NO_IN:0]   vec_cnt;
  logic [NO_IN:0]   err_cnt;
  logic             done;
  logic             pass;
  logic [NO_IN-1:0] first_err;
  logic             first_err_vld;

  modport master (
    output start, stimul, stimul_vld, vot,
    input  vec_cnt, err_cnt, done, pass, first_err, first_err_vld
  );

  modport slave (
    input  start, stimul, stimul_vld, vot,
    output vec_cnt, err_cnt, done, pass, first_err, first_err_vld
  );
endinterface

// File: rtl/vot_ref.sv
// Combinational majority reference: exp_vot is 1 when more than half the inputs are set.
module vot_ref #(
  parameter int unsigned NO_IN = 3
) (
  input  logic [NO_IN-1:0] stimul,
  output logic             exp_vot
);
  localparam int unsigned CW = $clog2(NO_IN + 1);

  logic [CW-1:0] ones;

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < NO_IN; i++) begin
      ones = ones + CW'(stimul[i]);
    end
  end

  assign exp_vot = (ones > CW'(NO_IN / 2));
endmodule

// File: rtl/vot_resp_check.sv
// Checks a majority voter's responses over all 2^NO_IN vectors, counting samples and mismatches.
// Define VOT_CHK_FIRST_ERR_EN to capture the first failing vector of each run.
module vot_resp_check
  import vot_chk_pkg::*;
#(
  parameter int unsigned NO_IN = 3
) (
  input logic             clk,
  input logic             rst,
  vot_resp_check_if.slave bus
);
  localparam int unsigned CNT_W = NO_IN + 1;
  localparam int unsigned NV    = num_vec(NO_IN);

  state_t           state;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [NV-1:0]    bitmap;
  logic             done;
  logic             pass;

  logic             exp_vot_c;
  logic             mis_c;
  logic             full_c;
  logic [NV-1:0]    bitmap_nxt_c;
  logic [CNT_W-1:0] vec_nxt_c;
  logic [CNT_W-1:0] err_nxt_c;

  vot_ref #(.NO_IN(NO_IN)) u_ref (
    .stimul  (bus.stimul),
    .exp_vot (exp_vot_c)
  );

  // Next values for one accepted sample; counters hold at all-ones.
  always_comb begin
    mis_c        = (bus.vot != exp_vot_c);
    bitmap_nxt_c = bitmap | (NV'(1) << bus.stimul);
    full_c       = &bitmap_nxt_c;
    vec_nxt_c    = (&vec_cnt) ? vec_cnt : vec_cnt + CNT_W'(1);
    err_nxt_c    = (mis_c && !(&err_cnt)) ? err_cnt + CNT_W'(1) : err_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      vec_cnt <= '0;
      err_cnt <= '0;
      bitmap  <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A sample arriving with start is dropped; only the restart counts.
          if (bus.start) begin
            state   <= RUN;
            vec_cnt <= '0;
            err_cnt <= '0;
            bitmap  <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        end
        RUN: begin
          if (bus.stimul_vld) begin
            vec_cnt <= vec_nxt_c;
            err_cnt <= err_nxt_c;
            bitmap  <= bitmap_nxt_c;
            if (full_c) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (err_nxt_c == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vec_cnt = vec_cnt;
  assign bus.err_cnt = err_cnt;
  assign bus.done    = done;
  assign bus.pass    = pass;

`ifdef VOT_CHK_FIRST_ERR_EN
  logic [NO_IN-1:0] first_err;
  logic             first_err_vld;

  // Holds the first mismatching vector until the next restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err     <= '0;
      first_err_vld <= 1'b0;
    end else if ((state != RUN) && bus.start) begin
      first_err     <= '0;
      first_err_vld <= 1'b0;
    end else if ((state == RUN) && bus.stimul_vld && mis_c && !first_err_vld) begin
      first_err     <= bus.stimul;
      first_err_vld <= 1'b1;
    end
  end

  assign bus.first_err     = first_err;
  assign bus.first_err_vld = first_err_vld;
`else
  assign bus.first_err     = '0;
  assign bus.first_err_vld = 1'b0;
`endif

endmodule

// File: tb/tb_vot_resp_check.sv
// Self-checking bench for vot_resp_check (NO_IN=3 and NO_IN=5 instances).
module tb_vot_resp_check;
  import vot_chk_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vot_resp_check_if #(.NO_IN(3)) bus3 ();
  vot_resp_check_if #(.NO_IN(5)) bus5 ();

  vot_resp_check #(.NO_IN(3)) u3 (.clk(clk), .rst(rst), .bus(bus3.slave));
  vot_resp_check #(.NO_IN(5)) u5 (.clk(clk), .rst(rst), .bus(bus5.slave));

  int n_tests = 0;
  int n_fail  = 0;

  localparam int SAT3 = 15;

  // Reference state for the NO_IN=3 checker.
  int       m_vec, m_err, m_fe;
  bit [7:0] m_seen;
  bit       m_run, m_done, m_pass, m_fev;

  typedef struct {
    int stim;
    bit vot;
    int vec;
    int err;
    bit done;
    bit pass;
  } vec_t;
  vec_t tbl[8];

  function automatic bit maj(input int v, input int n);
    return $countones(v) > (n / 2);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    m_vec = 0; m_err = 0; m_fe = 0; m_seen = '0;
    m_done = 0; m_pass = 0; m_fev = 0;
  endtask

  task automatic model_step(input bit s, input bit v, input int st, input bit vt);
    if (!m_run) begin
      if (s) begin
        model_clear();
        m_run = 1;
      end
    end else if (v) begin
      m_vec = (m_vec < SAT3) ? m_vec + 1 : SAT3;
      if (vt != maj(st, 3)) begin
        m_err = (m_err < SAT3) ? m_err + 1 : SAT3;
        if (!m_fev) begin
          m_fev = 1;
          m_fe  = st;
        end
      end
      m_seen[st] = 1'b1;
      if (&m_seen) begin
        m_run  = 0;
        m_done = 1;
        m_pass = (m_err == 0);
      end
    end
  endtask

  task automatic check3(input string tag);
    chk({tag, "/vec_cnt"}, int'(bus3.vec_cnt), m_vec);
    chk({tag, "/err_cnt"}, int'(bus3.err_cnt), m_err);
    chk({tag, "/done"}, int'(bus3.done), int'(m_done));
    chk({tag, "/pass"}, int'(bus3.pass), int'(m_pass));
`ifdef VOT_CHK_FIRST_ERR_EN
    chk({tag, "/first_err"}, int'(bus3.first_err), m_fe);
    chk({tag, "/first_err_vld"}, int'(bus3.first_err_vld), int'(m_fev));
`else
    chk({tag, "/first_err"}, int'(bus3.first_err), 0);
    chk({tag, "/first_err_vld"}, int'(bus3.first_err_vld), 0);
`endif
  endtask

  task automatic cyc3(input bit s, input bit v, input int st, input bit vt, input string tag);
    bus3.start      = s;
    bus3.stimul_vld = v;
    bus3.stimul     = 3'(st);
    bus3.vot        = vt;
    @(posedge clk);
    model_step(s, v, st, vt);
    #1;
    bus3.start      = 1'b0;
    bus3.stimul_vld = 1'b0;
    check3(tag);
  endtask

  task automatic samp(input int st, input bit vt, input string tag);
    cyc3(1'b0, 1'b1, st, vt, tag);
  endtask

  task automatic go(input string tag);
    cyc3(1'b1, 1'b0, 0, 1'b0, tag);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_rst(input string tag);
    rst = 1'b1;
    model_clear();
    m_run = 0;
    #2;
    check3(tag);
    chk({tag, "/state"}, int'(u3.state), int'(IDLE));
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int seq[9];
    rst = 1'b1;
    bus3.start = 1'b0; bus3.stimul_vld = 1'b0; bus3.stimul = '0; bus3.vot = 1'b0;
    bus5.start = 1'b0; bus5.stimul_vld = 1'b0; bus5.stimul = '0; bus5.vot = 1'b0;
    model_clear();
    m_run = 0;
    for (int i = 0; i < 8; i++) begin
      tbl[i].stim = i;
      tbl[i].vot  = maj(i, 3);
      tbl[i].vec  = i + 1;
      tbl[i].err  = 0;
      tbl[i].done = (i == 7);
      tbl[i].pass = (i == 7);
    end

    #12;
    check3("reset");
    chk("reset/state", int'(u3.state), int'(IDLE));
    chk("reset5/vec_cnt", int'(bus5.vec_cnt), 0);
    chk("reset5/done", int'(bus5.done), 0);
    rst = 1'b0;

    // All eight vectors answered correctly.
    go("t1_start");
    for (int i = 0; i < 8; i++) begin
      samp(tbl[i].stim, tbl[i].vot, "t1");
      chk("t1_tbl/vec_cnt", int'(bus3.vec_cnt), tbl[i].vec);
      chk("t1_tbl/err_cnt", int'(bus3.err_cnt), tbl[i].err);
      chk("t1_tbl/done", int'(bus3.done), int'(tbl[i].done));
      chk("t1_tbl/pass", int'(bus3.pass), int'(tbl[i].pass));
    end

    // Voter stuck at 0 on 3'b011.
    go("t2_start");
    for (int v = 0; v < 8; v++) samp(v, (v == 3) ? 1'b0 : maj(v, 3), "t2");
    chk("t2/err_cnt", int'(bus3.err_cnt), 1);
    chk("t2/done", int'(bus3.done), 1);
    chk("t2/pass", int'(bus3.pass), 0);
`ifdef VOT_CHK_FIRST_ERR_EN
    chk("t2/first_err", int'(bus3.first_err), 3);
    chk("t2/first_err_vld", int'(bus3.first_err_vld), 1);
`endif

    // Repeated vector: counted, coverage unaffected.
    seq = '{0, 1, 1, 2, 3, 4, 5, 6, 7};
    go("t3_start");
    for (int k = 0; k < 9; k++) begin
      samp(seq[k], maj(seq[k], 3), "t3");
      chk("t3/done_timing", int'(bus3.done), (k == 8) ? 1 : 0);
    end
    chk("t3/vec_cnt", int'(bus3.vec_cnt), 9);

    // Reset mid-run, samples ignored until a new start.
    go("t4_start");
    for (int v = 0; v < 4; v++) samp(v, maj(v, 3), "t4");
    do_rst("t4_rst");
    for (int v = 0; v < 3; v++) samp(v + 4, maj(v + 4, 3), "t4_idle");
    chk("t4_idle/vec_cnt", int'(bus3.vec_cnt), 0);
    go("t4_restart");
    samp(5, maj(5, 3), "t4_run");
    chk("t4_run/vec_cnt", int'(bus3.vec_cnt), 1);

    // Counter saturation at 4'hF.
    do_rst("t5_rst");
    go("t5_start");
    for (int k = 0; k < 20; k++) samp(0, 1'b1, "t5_sat");
    chk("t5/vec_sat", int'(bus3.vec_cnt), 15);
    chk("t5/err_sat", int'(bus3.err_cnt), 15);
    for (int v = 1; v < 8; v++) samp(v, maj(v, 3), "t5_fill");
    chk("t5/done", int'(bus3.done), 1);
    chk("t5/pass", int'(bus3.pass), 0);

    // Start with a sample in DONE: restart only.
    cyc3(1'b1, 1'b1, 5, 1'b0, "t6_restart");
    chk("t6/vec_cnt", int'(bus3.vec_cnt), 0);
    chk("t6/err_cnt", int'(bus3.err_cnt), 0);
    chk("t6/done", int'(bus3.done), 0);
    samp(2, 1'b0, "t6_run");
    cyc3(1'b1, 1'b1, 3, 1'b1, "t6_start_in_run");
    chk("t6/vec_cnt2", int'(bus3.vec_cnt), 2);

    // Randomised traffic against the reference.
    do_rst("rnd_rst");
    for (int k = 0; k < 400; k++) begin
      bit s, v, vt;
      int st;
      s  = ($urandom_range(0, 15) == 0);
      v  = ($urandom_range(0, 3) != 0);
      st = int'($urandom_range(0, 7));
      vt = ($urandom_range(0, 7) == 0) ? !maj(st, 3) : maj(st, 3);
      cyc3(s, v, st, vt, "rnd");
    end

    // NO_IN=5 with every response inverted.
    bus5.start = 1'b1;
    @(posedge clk); #1;
    bus5.start = 1'b0;
    for (int v = 0; v < 32; v++) begin
      bus5.stimul     = 5'(v);
      bus5.stimul_vld = 1'b1;
      bus5.vot        = !maj(v, 5);
      @(posedge clk); #1;
      if (v < 31) chk("t7/done_early", int'(bus5.done), 0);
    end
    bus5.stimul_vld = 1'b0;
    chk("t7/err_cnt", int'(bus5.err_cnt), 32);
    chk("t7/vec_cnt", int'(bus5.vec_cnt), 32);
    chk("t7/done", int'(bus5.done), 1);
    chk("t7/pass", int'(bus5.pass), 0);
`ifdef VOT_CHK_FIRST_ERR_EN
    chk("t7/first_err", int'(bus5.first_err), 0);
    chk("t7/first_err_vld", int'(bus5.first_err_vld), 1);
`else
    chk("t7/first_err_vld", int'(bus5.first_err_vld), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vot_resp_check.md
VOT_RESP_CHECK -- requirements
Module: vot_resp_check

Interface
REQ-001 The module SHALL have parameter NO_IN, default 3, giving the number of voter inputs (odd, 3..7).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1, a one-cycle pulse that begins a check run.
REQ-005 The module SHALL have port stimul, input, NO_IN, the vector currently applied to the DUT (bit0 = v1).
REQ-006 The module SHALL have port stimul_vld, input, 1, which qualifies stimul/vot for sampling this cycle.
REQ-007 The module SHALL have port vot, input, 1, the DUT majority result.
REQ-008 The module SHALL have port vec_cnt, output, NO_IN+1, the number of samples checked.
REQ-009 The module SHALL have port err_cnt, output, NO_IN+1, the number of mismatches.
REQ-010 The module SHALL have port done, output, 1, asserted once all 2^NO_IN distinct vectors have been checked.
REQ-011 The module SHALL have port pass, output, 1, asserted with done when err_cnt is 0.
REQ-012 The module SHALL have ports first_err, output, NO_IN, and first_err_vld, output, 1, which report the first failing vector.

Function
REQ-013 Expected result SHALL be 1 when popcount(stimul) > NO_IN/2, and 0 otherwise.
REQ-014 The FSM SHALL have states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE when the coverage bitmap becomes full; DONE->RUN on start.
REQ-015 Entering RUN SHALL clear vec_cnt, err_cnt, the coverage bitmap, done, pass, first_err and first_err_vld on the same edge.
REQ-016 In RUN with stimul_vld=1, the next edge SHALL increment vec_cnt, set bitmap[stimul], and increment err_cnt when vot differs from the expected value (latency 1 cycle).
REQ-017 stimul_vld SHALL be ignored in IDLE and DONE; start SHALL be ignored in RUN.
REQ-018 A repeated vector SHALL count in vec_cnt and err_cnt but SHALL NOT advance coverage.
REQ-019 vec_cnt and err_cnt SHALL saturate at all-ones, with no wrap-around.
REQ-020 done SHALL rise on the edge that sets the last bitmap bit, including that sample's error update; pass = done AND (err_cnt==0), registered.
REQ-021 When start and stimul_vld occur in the same cycle in IDLE or DONE, the sample SHALL be discarded and only the restart takes effect.

Reset
REQ-022 When rst is asserted, the state SHALL be IDLE and all outputs, counters and the bitmap SHALL be 0, independent of clk.
REQ-023 When reset is asserted mid-RUN, the run SHALL be aborted and a new start SHALL be required.

Configuration
REQ-024 With macro VOT_CHK_FIRST_ERR_EN defined, the first mismatch of a run SHALL load stimul into first_err and set first_err_vld; later mismatches SHALL leave both unchanged until restart.
REQ-025 Without VOT_CHK_FIRST_ERR_EN, first_err and first_err_vld SHALL be tied to 0 and no capture register SHALL exist.

Structure
REQ-026 The FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL reside in shared package/include vot_chk_pkg.
REQ-027 The expected-value model SHALL be a combinational sub-module vot_ref (NO_IN parameter; input stimul, output exp_vot).

Verification
REQ-028 The bench SHALL cover: reset, start, then vectors 0..7 with a correct DUT -> done=1, pass=1, vec_cnt=8, err_cnt=0 after the 8th sample.
REQ-029 The bench SHALL cover: a DUT forcing vot=0 on vector 3'b011 (with the macro) -> err_cnt=1, first_err=3'b011, first_err_vld=1, pass=0.
REQ-030 The bench SHALL cover: vectors 0,1,1,2..7 -> vec_cnt=9, done rises on vector 7 and not before.
REQ-031 The bench SHALL cover: rst pulsed after 4 samples -> all outputs 0, state IDLE; stimul_vld ignored until start.
REQ-032 The bench SHALL cover: NO_IN=5 with the DUT inverted for all 32 vectors -> err_cnt=32, done=1, pass=0.
REQ-033 The bench SHALL cover: start pulsed in DONE together with stimul_vld -> counters cleared, that sample not counted.
